secuenciador_melodia: RTL and testbench
=======================================

Name: secuenciador_melodia

Overview:
Playback controller for the note generator of the music box. It holds a small programmable melody table of (note, duration) entries and steps through it on a millisecond tick. Each cycle it drives a one-hot note select to the existing 7-note divisor/mux datapath. Live keys always pre-empt playback: they pause the melody, which resumes where it stopped once all keys are released.

Parameters:
TICK_DIV, 50000, clk cycles per duration tick (1 ms at 50 MHz); must be >= 2.
AW, 4, melody table address width (table depth = 2**AW).
DUR_W, 8, duration field width in ticks.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low
wr_en  in  1  table write strobe
wr_addr  in  AW  table write address
wr_note  in  3  note code: 0 = rest, 1..7 = DO..SI
wr_dur  in  DUR_W  duration in ticks; 0 is treated as 1
last_idx  in  AW  index of the final entry of the melody
play  in  1  start pulse
stop  in  1  abort pulse
loop_en  in  1  restart at entry 0 after last_idx
teclas  in  7  live keys, bit0 = DO … bit6 = SI
nota_sel  out  7  registered one-hot note select (all zeros = silence)
busy  out  1  high in LOAD, PLAY or PAUSE
done  out  1  one-cycle pulse when a non-looping melody ends
pos  out  AW  index of the current or next entry

Behaviour:
- Reset (reset = 0 at a clk edge):
  - state = IDLE; nota_sel, busy, done, pos, tick prescaler and dur_cnt all 0.
  - Table contents are not cleared.
- Table writes: wr_en writes {wr_note, wr_dur} at wr_addr on the clk edge, in any state. A write to the entry currently playing takes effect only at its next LOAD.
- Live-key priority: the lowest set bit of teclas wins. Result is one-hot of that bit, or 0 when no key is pressed.
- Note decode: code c in 1..7 drives nota_sel bit c-1; code 0 drives 0.
- Tick: prescaler counts 0..TICK_DIV-1 and asserts tick for one cycle at the wrap.
  - Prescaler is cleared in LOAD.
  - It counts only in PLAY and is frozen in PAUSE and IDLE.
- States:
  - IDLE:
    - nota_sel <= live-key encode (1-cycle latency).
    - play -> LOAD with pos <= 0.
  - LOAD (one cycle):
    - note_reg <= table[pos].note.
    - dur_cnt <= table[pos].dur, with 0 loaded as 1.
    - -> PLAY.
  - PLAY:
    - nota_sel <= decode(note_reg).
    - Any teclas bit set -> PAUSE.
    - On tick, dur_cnt decrements.
    - On tick with dur_cnt == 1, the entry ends:
      - pos != last_idx: pos <= pos+1, -> LOAD.
      - pos == last_idx with loop_en = 1: pos <= 0, -> LOAD.
      - pos == last_idx with loop_en = 0: -> IDLE, done = 1 for one cycle, pos <= 0.
    - A key press and an entry end in the same cycle: the key wins. -> PAUSE with dur_cnt held at 1; the entry ends on the first tick after resume.
  - PAUSE:
    - nota_sel <= live-key encode.
    - dur_cnt and prescaler held.
    - teclas == 0 -> PLAY; note_reg output resumes the next cycle.
- Latency: play sampled at edge N gives LOAD in cycle N+1, PLAY from edge N+2. nota_sel shows entry 0 from cycle N+3.
- stop: in any state -> IDLE at the next edge. No done pulse, pos <= 0.
  - stop and play in the same cycle: stop wins.
- play in LOAD, PLAY or PAUSE is ignored; there is no restart.
- last_idx and loop_en are sampled at each entry end, so changing them mid-play is legal.
- Sizing: dur_cnt is DUR_W bits. The maximum entry length is (2**DUR_W - 1) * TICK_DIV cycles.
- A rest entry (code 0) produces nota_sel = 0 for its full duration.

Test Plan:
1. TICK_DIV=4. Write entries 0:(1,2), 1:(3,1), 2:(0,1), 3:(7,3); last_idx=3, loop_en=0; pulse play.
   -> nota_sel sequence: 0000001 for 8 cycles, 0000100 for 4, 0000000 for 4, 1000000 for 12, each entry separated by one LOAD cycle.
   -> done pulses once; busy falls together with done.
2. Same table, loop_en=1.
   -> After entry 3, pos returns to 0 and 0000001 reappears. No done pulse. busy stays 1 until stop.
   -> stop then gives IDLE and nota_sel=0 on the next edge.
3. During entry 0 (dur 2), hold teclas=0010100 for 20 cycles.
   -> nota_sel=0000100 (lowest bit) the cycle after the press.
   -> On release, 0000001 resumes, and the remaining duration equals the value before the pause: total PLAY cycles for entry 0 = 8.
4. Write entry 0 with dur=0.
   -> It plays for exactly 1 tick (4 cycles).
   -> Assert play and stop in the same cycle: state stays IDLE, busy=0.
5. Drive reset=0 for one edge mid-PLAY.
   -> All outputs 0 at the next edge.
   -> The previously written table still plays correctly after a new play pulse.
6. In IDLE with teclas=1000000 -> nota_sel=1000000 one cycle later. A play pulse while in PLAY does not reset pos.

Source files
------------

// File: rtl/secuenciador_melodia.sv
// -----------------------------------------------------------------------------
// secuenciador_melodia
//
// Playback controller for the music-box note generator. It holds a
// programmable table of (note, duration) entries and steps through it on a
// prescaled duration tick. Every cycle it produces a registered one-hot note
// select for the 7-note divisor/mux datapath. Live keys pre-empt playback:
// they pause the melody, which resumes where it stopped once all keys are
// released.
//
// Parameters:
//   TICK_DIV  clk cycles per duration tick (>= 2)
//   AW        table address width (depth = 2**AW)
//   DUR_W     duration field width, in ticks
//
// Ports:
//   i_clk        system clock
//   i_reset      synchronous, active-low reset
//   i_wr_en      table write strobe
//   i_wr_addr    table write address
//   i_wr_note    note code: 0 = rest, 1..7 = DO..SI
//   i_wr_dur     duration in ticks (0 plays as 1)
//   i_last_idx   index of the final melody entry
//   i_play       start pulse (ignored unless idle)
//   i_stop       abort pulse (wins over play)
//   i_loop_en    restart at entry 0 after i_last_idx
//   i_teclas     live keys, bit0 = DO .. bit6 = SI
//   o_nota_sel   registered one-hot note select (0 = silence)
//   o_busy       high while loading, playing or paused
//   o_done       one-cycle pulse when a non-looping melody ends
//   o_pos        index of the current or next entry
// -----------------------------------------------------------------------------
module secuenciador_melodia #(
    parameter int unsigned TICK_DIV = 50000,
    parameter int unsigned AW       = 4,
    parameter int unsigned DUR_W    = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [2:0]       i_wr_note,
    input  logic [DUR_W-1:0] i_wr_dur,
    input  logic [AW-1:0]    i_last_idx,
    input  logic             i_play,
    input  logic             i_stop,
    input  logic             i_loop_en,
    input  logic [6:0]       i_teclas,
    output logic [6:0]       o_nota_sel,
    output logic             o_busy,
    output logic             o_done,
    output logic [AW-1:0]    o_pos
);

    localparam int unsigned DEPTH = 2 ** AW;
    localparam int unsigned PW    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned EW    = 3 + DUR_W;

    typedef enum logic [1:0] {StIdle, StLoad, StPlay, StPause} state_e;

    // Melody table, {note, duration} per entry; deliberately not reset.
    logic [EW-1:0]    r_mem [DEPTH];

    state_e           r_state, w_state_d;
    logic [AW-1:0]    r_pos, w_pos_d;
    logic [2:0]       r_note, w_note_d;
    logic [DUR_W-1:0] r_dur_cnt, w_dur_d;
    logic [PW-1:0]    r_presc, w_presc_d;
    logic [6:0]       r_nota_sel, w_nota_d;
    logic             r_done, w_done_d;

    logic [EW-1:0]    w_entry;
    logic [2:0]       w_entry_note;
    logic [DUR_W-1:0] w_entry_dur;
    logic [6:0]       w_key_oh;
    logic             w_key_any;
    logic             w_tick;

    function automatic logic [6:0] f_decode(input logic [2:0] c);
        logic [6:0] v;
        case (c)
            3'd1:    v = 7'b0000001;
            3'd2:    v = 7'b0000010;
            3'd3:    v = 7'b0000100;
            3'd4:    v = 7'b0001000;
            3'd5:    v = 7'b0010000;
            3'd6:    v = 7'b0100000;
            3'd7:    v = 7'b1000000;
            default: v = 7'b0000000;
        endcase
        return v;
    endfunction

    // Isolate the lowest set key: x & -x.
    assign w_key_oh     = i_teclas & (~i_teclas + 7'd1);
    assign w_key_any    = |i_teclas;

    assign w_entry      = r_mem[r_pos];
    assign w_entry_note = w_entry[EW-1 -: 3];
    assign w_entry_dur  = w_entry[DUR_W-1:0];

    assign w_tick       = (r_presc == PW'(TICK_DIV - 1));

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= {i_wr_note, i_wr_dur};
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_pos_d   = r_pos;
        w_note_d  = r_note;
        w_dur_d   = r_dur_cnt;
        w_presc_d = r_presc;
        w_nota_d  = r_nota_sel;
        w_done_d  = 1'b0;

        if (i_stop) begin
            w_state_d = StIdle;
            w_pos_d   = '0;
            w_nota_d  = w_key_oh;
        end else begin
            case (r_state)
                StIdle: begin
                    w_nota_d = w_key_oh;
                    if (i_play) begin
                        w_state_d = StLoad;
                        w_pos_d   = '0;
                    end
                end

                StLoad: begin
                    w_note_d  = w_entry_note;
                    w_dur_d   = (w_entry_dur == '0) ? DUR_W'(1) : w_entry_dur;
                    w_presc_d = '0;
                    w_nota_d  = '0;
                    w_state_d = StPlay;
                end

                StPlay: begin
                    if (w_key_any) begin
                        // Keys win over a coinciding tick: counters stay put,
                        // so a pending entry end happens on the first tick
                        // after resume.
                        w_nota_d  = w_key_oh;
                        w_state_d = StPause;
                    end else begin
                        w_nota_d = f_decode(r_note);
                        if (w_tick) begin
                            w_presc_d = '0;
                            w_dur_d   = r_dur_cnt - DUR_W'(1);
                            if (r_dur_cnt <= DUR_W'(1)) begin
                                if (r_pos != i_last_idx) begin
                                    w_pos_d   = r_pos + AW'(1);
                                    w_state_d = StLoad;
                                end else if (i_loop_en) begin
                                    w_pos_d   = '0;
                                    w_state_d = StLoad;
                                end else begin
                                    w_pos_d   = '0;
                                    w_done_d  = 1'b1;
                                    w_state_d = StIdle;
                                end
                            end
                        end else begin
                            w_presc_d = r_presc + PW'(1);
                        end
                    end
                end

                StPause: begin
                    w_nota_d = w_key_oh;
                    if (!w_key_any) begin
                        w_state_d = StPlay;
                    end
                end

                default: begin
                    w_state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state    <= StIdle;
            r_pos      <= '0;
            r_note     <= '0;
            r_dur_cnt  <= '0;
            r_presc    <= '0;
            r_nota_sel <= '0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_pos      <= w_pos_d;
            r_note     <= w_note_d;
            r_dur_cnt  <= w_dur_d;
            r_presc    <= w_presc_d;
            r_nota_sel <= w_nota_d;
            r_done     <= w_done_d;
        end
    end

    assign o_nota_sel = r_nota_sel;
    assign o_busy     = (r_state != StIdle);
    assign o_done     = r_done;
    assign o_pos      = r_pos;

endmodule

// File: tb/tb_secuenciador_melodia.sv
module tb_secuenciador_melodia;

    logic       clk;
    logic       reset;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [2:0] wr_note;
    logic [7:0] wr_dur;
    logic [3:0] last_idx;
    logic       play;
    logic       stop;
    logic       loop_en;
    logic [6:0] teclas;
    logic [6:0] nota_sel;
    logic       busy;
    logic       done;
    logic [3:0] pos;

    int n_cmp;
    int n_err;

    secuenciador_melodia #(
        .TICK_DIV (4),
        .AW       (4),
        .DUR_W    (8)
    ) u_dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_wr_en    (wr_en),
        .i_wr_addr  (wr_addr),
        .i_wr_note  (wr_note),
        .i_wr_dur   (wr_dur),
        .i_last_idx (last_idx),
        .i_play     (play),
        .i_stop     (stop),
        .i_loop_en  (loop_en),
        .i_teclas   (teclas),
        .o_nota_sel (nota_sel),
        .o_busy     (busy),
        .o_done     (done),
        .o_pos      (pos)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no end, want $finish");
        $fatal(1);
    end

    // Inputs change and outputs are sampled on the falling edge.
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic write_entry(input logic [3:0] a, input logic [2:0] n, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_note = n;
        wr_dur  = d;
        cyc();
        wr_en   = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
    endtask

    // Table 0:(1,2) 1:(3,1) 2:(0,1) 3:(7,3) with TICK_DIV=4. k counts
    // samples after the play edge: k=0 LOAD, entry 0 visible k=2..9,
    // entry 1 k=11..14, rest k=16..19, entry 3 k=21..32, gaps are LOAD.
    task automatic play_and_check(input string tag, input bit lp, input int kmax);
        logic [6:0] en;
        logic [3:0] ep;
        logic       eb;
        logic       ed;
        loop_en  = lp;
        last_idx = 4'd3;
        play     = 1'b1;
        cyc();
        play     = 1'b0;
        for (int k = 0; k <= kmax; k++) begin
            if (k >= 2 && k <= 9)                en = 7'b0000001;
            else if (k >= 11 && k <= 14)         en = 7'b0000100;
            else if (k >= 21 && k <= 32)         en = 7'b1000000;
            else if (lp && k >= 34 && k <= 41)   en = 7'b0000001;
            else                                 en = 7'b0000000;
            if (k <= 8)       ep = 4'd0;
            else if (k <= 13) ep = 4'd1;
            else if (k <= 18) ep = 4'd2;
            else if (k <= 31) ep = 4'd3;
            else              ep = 4'd0;
            eb = lp ? 1'b1 : (k <= 31);
            ed = !lp && (k == 32);

            n_cmp++;
            if (nota_sel !== en) begin
                n_err++;
                $display("FAIL %s nota_sel k=%0d: got %b want %b", tag, k, nota_sel, en);
            end
            n_cmp++;
            if (pos !== ep) begin
                n_err++;
                $display("FAIL %s pos k=%0d: got %0d want %0d", tag, k, pos, ep);
            end
            n_cmp++;
            if (busy !== eb) begin
                n_err++;
                $display("FAIL %s busy k=%0d: got %b want %b", tag, k, busy, eb);
            end
            n_cmp++;
            if (done !== ed) begin
                n_err++;
                $display("FAIL %s done k=%0d: got %b want %b", tag, k, done, ed);
            end
            if (k < kmax) cyc();
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        cyc();
        cyc();
        n_cmp++;
        if (nota_sel !== 7'd0) begin
            n_err++;
            $display("FAIL reset nota_sel: got %b want 0000000", nota_sel);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset busy: got %b want 0", busy);
        end
        n_cmp++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL reset done: got %b want 0", done);
        end
        n_cmp++;
        if (pos !== 4'd0) begin
            n_err++;
            $display("FAIL reset pos: got %0d want 0", pos);
        end
        reset = 1'b1;
        cyc();
    endtask

    task automatic load_table();
        write_entry(4'd0, 3'd1, 8'd2);
        write_entry(4'd1, 3'd3, 8'd1);
        write_entry(4'd2, 3'd0, 8'd1);
        write_entry(4'd3, 3'd7, 8'd3);
    endtask

    task automatic test_single_shot();
        load_table();
        play_and_check("single", 1'b0, 33);
    endtask

    task automatic test_loop_and_stop();
        play_and_check("loop", 1'b1, 40);
        do_stop();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL loop_stop busy: got %b want 0", busy);
        end
        n_cmp++;
        if (nota_sel !== 7'd0) begin
            n_err++;
            $display("FAIL loop_stop nota_sel: got %b want 0000000", nota_sel);
        end
        n_cmp++;
        if (pos !== 4'd0) begin
            n_err++;
            $display("FAIL loop_stop pos: got %0d want 0", pos);
        end
        cyc();
        n_cmp++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL loop_stop done: got %b want 0", done);
        end
        loop_en = 1'b0;
    endtask

    task automatic test_key_pause();
        int ones;
        ones     = 0;
        loop_en  = 1'b0;
        last_idx = 4'd3;
        play     = 1'b1;
        cyc();
        play     = 1'b0;
        for (int k = 0; k <= 31; k++) begin
            if (nota_sel === 7'b0000001) ones++;
            if (k == 5 || k == 24) begin
                n_cmp++;
                if (nota_sel !== 7'b0000100) begin
                    n_err++;
                    $display("FAIL pause_key nota_sel k=%0d: got %b want 0000100", k, nota_sel);
                end
                n_cmp++;
                if (busy !== 1'b1) begin
                    n_err++;
                    $display("FAIL pause_key busy k=%0d: got %b want 1", k, busy);
                end
            end
            if (k == 25) begin
                n_cmp++;
                if (nota_sel !== 7'b0000000) begin
                    n_err++;
                    $display("FAIL pause_release nota_sel: got %b want 0000000", nota_sel);
                end
            end
            if (k == 26) begin
                n_cmp++;
                if (nota_sel !== 7'b0000001) begin
                    n_err++;
                    $display("FAIL pause_resume nota_sel: got %b want 0000001", nota_sel);
                end
            end
            if (k == 29) begin
                n_cmp++;
                if (pos !== 4'd0) begin
                    n_err++;
                    $display("FAIL pause_pos29 pos: got %0d want 0", pos);
                end
            end
            if (k == 30) begin
                n_cmp++;
                if (pos !== 4'd1) begin
                    n_err++;
                    $display("FAIL pause_pos30 pos: got %0d want 1", pos);
                end
            end
            if (k == 4)  teclas = 7'b0010100;
            if (k == 24) teclas = 7'b0000000;
            cyc();
        end
        n_cmp++;
        if (ones != 8) begin
            n_err++;
            $display("FAIL pause_total entry0 cycles: got %0d want 8", ones);
        end
        do_stop();
    endtask

    task automatic test_zero_dur_and_play_stop();
        logic [6:0] en;
        write_entry(4'd0, 3'd1, 8'd0);
        last_idx = 4'd0;
        loop_en  = 1'b0;
        play     = 1'b1;
        cyc();
        play     = 1'b0;
        for (int k = 0; k <= 6; k++) begin
            en = (k >= 2 && k <= 5) ? 7'b0000001 : 7'b0000000;
            n_cmp++;
            if (nota_sel !== en) begin
                n_err++;
                $display("FAIL dur0 nota_sel k=%0d: got %b want %b", k, nota_sel, en);
            end
            n_cmp++;
            if (busy !== (k <= 4)) begin
                n_err++;
                $display("FAIL dur0 busy k=%0d: got %b want %b", k, busy, (k <= 4));
            end
            n_cmp++;
            if (done !== (k == 5)) begin
                n_err++;
                $display("FAIL dur0 done k=%0d: got %b want %b", k, done, (k == 5));
            end
            if (k < 6) cyc();
        end
        write_entry(4'd0, 3'd1, 8'd2);
        last_idx = 4'd3;
        play = 1'b1;
        stop = 1'b1;
        cyc();
        play = 1'b0;
        stop = 1'b0;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL play_stop busy: got %b want 0", busy);
        end
        cyc();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL play_stop busy2: got %b want 0", busy);
        end
        n_cmp++;
        if (nota_sel !== 7'd0) begin
            n_err++;
            $display("FAIL play_stop nota_sel: got %b want 0000000", nota_sel);
        end
    endtask

    task automatic test_reset_mid_play();
        last_idx = 4'd3;
        loop_en  = 1'b0;
        play     = 1'b1;
        cyc();
        play     = 1'b0;
        for (int k = 0; k < 4; k++) cyc();
        n_cmp++;
        if (nota_sel !== 7'b0000001) begin
            n_err++;
            $display("FAIL midreset pre nota_sel: got %b want 0000001", nota_sel);
        end
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        n_cmp++;
        if (nota_sel !== 7'd0) begin
            n_err++;
            $display("FAIL midreset nota_sel: got %b want 0000000", nota_sel);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL midreset busy: got %b want 0", busy);
        end
        n_cmp++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL midreset done: got %b want 0", done);
        end
        n_cmp++;
        if (pos !== 4'd0) begin
            n_err++;
            $display("FAIL midreset pos: got %0d want 0", pos);
        end
        cyc();
        play_and_check("after_reset", 1'b0, 33);
    endtask

    task automatic test_idle_keys_and_replay();
        teclas = 7'b1000000;
        cyc();
        n_cmp++;
        if (nota_sel !== 7'b1000000) begin
            n_err++;
            $display("FAIL idle_key_si nota_sel: got %b want 1000000", nota_sel);
        end
        teclas = 7'b0011000;
        cyc();
        n_cmp++;
        if (nota_sel !== 7'b0001000) begin
            n_err++;
            $display("FAIL idle_key_prio nota_sel: got %b want 0001000", nota_sel);
        end
        teclas = 7'b0000000;
        cyc();
        n_cmp++;
        if (nota_sel !== 7'b0000000) begin
            n_err++;
            $display("FAIL idle_key_off nota_sel: got %b want 0000000", nota_sel);
        end
        last_idx = 4'd3;
        loop_en  = 1'b0;
        play     = 1'b1;
        cyc();
        play     = 1'b0;
        for (int k = 0; k < 10; k++) cyc();
        n_cmp++;
        if (pos !== 4'd1) begin
            n_err++;
            $display("FAIL replay_pre pos: got %0d want 1", pos);
        end
        play = 1'b1;
        cyc();
        play = 1'b0;
        n_cmp++;
        if (pos !== 4'd1) begin
            n_err++;
            $display("FAIL replay pos: got %0d want 1", pos);
        end
        n_cmp++;
        if (nota_sel !== 7'b0000100) begin
            n_err++;
            $display("FAIL replay nota_sel: got %b want 0000100", nota_sel);
        end
        cyc();
        cyc();
        cyc();
        n_cmp++;
        if (pos !== 4'd2) begin
            n_err++;
            $display("FAIL replay_next pos: got %0d want 2", pos);
        end
        do_stop();
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        reset    = 1'b0;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_note  = '0;
        wr_dur   = '0;
        last_idx = '0;
        play     = 1'b0;
        stop     = 1'b0;
        loop_en  = 1'b0;
        teclas   = '0;

        test_reset();
        test_single_shot();
        test_loop_and_stop();
        test_key_pause();
        test_zero_dur_and_play_stop();
        test_reset_mid_play();
        test_idle_keys_and_replay();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
